// File: rtl/fetch_pkg.sv
// fetch_pkg: instruction format and fetch buffer entry types shared by the fetch stage
package fetch_pkg;

    localparam int FETCH_ROM_DEPTH = 16;
    localparam int FETCH_ADDR_BITS = $clog2(FETCH_ROM_DEPTH);
    localparam int FETCH_BUF_DEPTH = 2;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'h03,
        OP_IMM    = 7'h13,
        OP_STORE  = 7'h23,
        OP_REG    = 7'h33,
        OP_BRANCH = 7'h63,
        OP_JAL    = 7'h6f
    } opcode_t;

    typedef logic [4:0]  reg_t;
    typedef logic [14:0] imm_t;

    typedef struct packed {
        imm_t    imm;
        reg_t    rs1;
        reg_t    rd;
        opcode_t opcode;
    } instruction_t;

    // pc width follows the default ROM; a different ROM_DEPTH needs this retyped
    typedef struct packed {
        logic [FETCH_ADDR_BITS-1:0] pc;
        instruction_t               ins;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry registered FIFO holding fetched words for decode
import fetch_pkg::*;

module fetch_fifo #(
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   arstn,
    input  logic   flush,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int CW = $clog2(FETCH_BUF_DEPTH + 1);

    entry_t        head_q, head_d;
    entry_t        tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] after_pop;
    logic          do_pop, do_push;

    // head slot is always the oldest entry; a pop shifts the tail forward
    always_comb begin
        do_pop    = pop && (count_q != '0);
        do_push   = push && ((count_q != CW'(FETCH_BUF_DEPTH)) || do_pop);
        after_pop = count_q - CW'(do_pop);
        head_d    = (do_push && after_pop == CW'(0)) ? din : (do_pop ? tail_q : head_q);
        tail_d    = (do_push && after_pop == CW'(1)) ? din : tail_q;
        count_d   = flush ? '0 : after_pop + CW'(do_push);
    end

    // storage and occupancy; reset clears data so outputs read zero
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign full  = (count_q == CW'(FETCH_BUF_DEPTH));
    assign empty = (count_q == '0);
    assign head  = head_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, ROM addressing, redirect and halt control feeding decode
import fetch_pkg::*;

module fetch_stage #(
    parameter  int WORD_WIDTH = 32,
    parameter  int ROM_DEPTH  = FETCH_ROM_DEPTH,
    localparam int ADDR_BITS  = $clog2(ROM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  arstn,
    output logic [ADDR_BITS-1:0]  rom_addr_o,
    input  logic [WORD_WIDTH-1:0] rom_data_i,
    input  logic                  branch_valid_i,
    input  logic [ADDR_BITS-1:0]  branch_target_i,
    output logic                  ins_valid_o,
    input  logic                  ins_ready_i,
    output logic [WORD_WIDTH-1:0] ins_o,
    output logic [ADDR_BITS-1:0]  ins_pc_o,
    output logic                  done_o
);

    logic [ADDR_BITS:0] pc_q, pc_d;
    logic               halted, push, pop, full, empty;
    fetch_entry_t       fetch_entry, head;

    // fetch whenever a slot is free this edge; a redirect suppresses fetch and reloads the PC
    always_comb begin
        halted          = (pc_q >= (ADDR_BITS + 1)'(ROM_DEPTH));
        pop             = ins_valid_o && ins_ready_i;
        push            = !halted && !branch_valid_i && (!full || pop);
        pc_d            = branch_valid_i ? {1'b0, branch_target_i} : (push ? pc_q + 1'b1 : pc_q);
        fetch_entry.pc  = pc_q[ADDR_BITS-1:0];
        fetch_entry.ins = instruction_t'(rom_data_i);
    end

    // program counter, one bit wider than the ROM address so the end is visible
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    fetch_fifo #(.entry_t(fetch_entry_t)) u_fifo (
        .clk   (clk),
        .arstn (arstn),
        .flush (branch_valid_i),
        .push  (push),
        .pop   (pop),
        .din   (fetch_entry),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign rom_addr_o  = pc_q[ADDR_BITS-1:0];
    assign ins_valid_o = !empty;
    assign ins_o       = head.ins;
    assign ins_pc_o    = head.pc;
    assign done_o      = halted && empty;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: queue-based model check every cycle plus directed delivery-sequence checks
module tb_fetch_stage;

    logic        clk = 0;
    logic        arstn = 0;
    logic        branch_valid = 0;
    logic        ins_ready = 1;
    logic [3:0]  branch_target = 0;
    logic [3:0]  rom_addr, ins_pc;
    logic [31:0] rom_data, ins;
    logic        ins_valid, done;

    int          checks = 0;
    int          passed = 0;
    int          mq_pc[$];
    logic [31:0] mq_w[$];
    int          mpc = 0;
    int          acc[$];
    int          n;

    function automatic logic [31:0] rom_word(int a);
        return {16'hC0DE, 8'(a), ~8'(a)};
    endfunction

    assign rom_data = rom_word(int'(rom_addr));

    fetch_stage dut (
        .clk             (clk),
        .arstn           (arstn),
        .rom_addr_o      (rom_addr),
        .rom_data_i      (rom_data),
        .branch_valid_i  (branch_valid),
        .branch_target_i (branch_target),
        .ins_valid_o     (ins_valid),
        .ins_ready_i     (ins_ready),
        .ins_o           (ins),
        .ins_pc_o        (ins_pc),
        .done_o          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // reference: a plain queue of {pc, word}; decode takes the front, fetch appends while room remains
    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            mq_pc.delete();
            mq_w.delete();
            mpc = 0;
        end else if (branch_valid) begin
            mq_pc.delete();
            mq_w.delete();
            mpc = int'(branch_target);
        end else begin
            if (mq_pc.size() != 0 && ins_ready) begin
                void'(mq_pc.pop_front());
                void'(mq_w.pop_front());
            end
            if (mpc < 16 && mq_pc.size() < 2) begin
                mq_pc.push_back(mpc);
                mq_w.push_back(rom_word(mpc));
                mpc++;
            end
        end
    end

    // compare DUT against the reference mid-cycle and log accepted PCs
    always @(negedge clk) begin
        if (!arstn) begin
            check("rst_valid", ins_valid, 0);
            check("rst_ins", ins, 0);
            check("rst_pc", ins_pc, 0);
            check("rst_done", done, 0);
            check("rst_addr", rom_addr, 0);
        end else begin
            check("valid", ins_valid, mq_pc.size() != 0);
            if (mq_pc.size() != 0) begin
                check("ins_pc", ins_pc, mq_pc[0]);
                check("ins", ins, mq_w[0]);
            end
            check("done", done, mpc >= 16 && mq_pc.size() == 0);
            if (mpc < 16) check("rom_addr", rom_addr, mpc);
            if (ins_valid && ins_ready) acc.push_back(int'(ins_pc));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        arstn = 0;
        branch_valid = 0;
        ins_ready = 1;
        repeat (2) tick;
        check("reset_valid", ins_valid, 0);
        check("reset_done", done, 0);
        arstn = 1;
    endtask

    task automatic run_to_done(input string name, output int cycles);
        cycles = 0;
        do begin
            tick;
            cycles++;
        end while (!done && cycles < 100);
        check({name, "_done"}, done, 1);
    endtask

    task automatic expect_seq(input string name, input int exp[$]);
        check({name, "_len"}, acc.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check(name, i < acc.size() ? acc[i] : -1, exp[i]);
    endtask

    initial begin
        int exp[$];
        // straight-line run
        do_reset;
        acc.delete();
        run_to_done("straight", n);
        check("straight_cycles", n, 17);
        exp.delete();
        for (int i = 0; i < 16; i++) exp.push_back(i);
        expect_seq("straight_seq", exp);

        // backpressure from the start
        do_reset;
        ins_ready = 0;
        repeat (6) tick;
        check("bp_valid", ins_valid, 1);
        check("bp_pc", ins_pc, 0);
        check("bp_ins", ins, 32'hC0DE00FF);
        check("bp_addr", rom_addr, 2);
        ins_ready = 1;
        acc.delete();
        run_to_done("bp", n);
        expect_seq("bp_seq", exp);

        // redirect with two entries buffered, no pop
        do_reset;
        acc.delete();
        repeat (4) tick;
        check("br_head", ins_pc, 3);
        ins_ready = 0;
        tick;
        check("br_addr", rom_addr, 5);
        branch_valid = 1;
        branch_target = 9;
        tick;
        branch_valid = 0;
        ins_ready = 1;
        check("br_bubble", ins_valid, 0);
        tick;
        check("br_tvalid", ins_valid, 1);
        check("br_tpc", ins_pc, 9);
        check("br_tins", ins, 32'hC0DE09F6);
        run_to_done("br", n);
        exp = '{0, 1, 2, 9, 10, 11, 12, 13, 14, 15};
        expect_seq("br_seq", exp);

        // redirect while popping a full buffer
        do_reset;
        acc.delete();
        repeat (4) tick;
        ins_ready = 0;
        tick;
        ins_ready = 1;
        branch_valid = 1;
        branch_target = 9;
        tick;
        branch_valid = 0;
        check("brp_bubble", ins_valid, 0);
        run_to_done("brp", n);
        exp = '{0, 1, 2, 3, 9, 10, 11, 12, 13, 14, 15};
        expect_seq("brp_seq", exp);

        // halt then re-arm by redirect
        check("halt_done", done, 1);
        acc.delete();
        branch_valid = 1;
        branch_target = 5;
        tick;
        branch_valid = 0;
        check("rearm_done", done, 0);
        run_to_done("rearm", n);
        exp.delete();
        for (int i = 5; i < 16; i++) exp.push_back(i);
        expect_seq("rearm_seq", exp);

        // asynchronous reset between edges
        do_reset;
        ins_ready = 0;
        repeat (3) tick;
        check("ar_pre_valid", ins_valid, 1);
        #1 arstn = 0;
        #1;
        check("ar_valid", ins_valid, 0);
        check("ar_pc", ins_pc, 0);
        #1 arstn = 1;
        ins_ready = 1;
        acc.delete();
        run_to_done("ar", n);
        check("ar_cycles", n, 17);
        exp.delete();
        for (int i = 0; i < 16; i++) exp.push_back(i);
        expect_seq("ar_seq", exp);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of decode and the sole address master of the instruction ROM.
- Holds the program counter and drives the ROM address; the ROM read is combinational.
- Captures each returned word with its PC into a 2-entry buffer, presented to decode over a valid/ready handshake.
- Handles branch redirects by flushing in-flight entries, and halts after the last ROM word is fetched.

Parameters:
- WORD_WIDTH, 32, instruction word width; must equal $bits(fetch_pkg::instruction_t).
- ROM_DEPTH, 16, number of ROM words; the program occupies addresses 0..ROM_DEPTH-1.
- ADDR_BITS, $clog2(ROM_DEPTH), localparam; ROM address width.

Ports:
- clk  input  1  clock, all state on rising edge.
- arstn  input  1  asynchronous active-low reset.
- rom_addr_o  output  ADDR_BITS  ROM read address.
- rom_data_i  input  WORD_WIDTH  ROM word at rom_addr_o, same cycle.
- branch_valid_i  input  1  redirect request from execute.
- branch_target_i  input  ADDR_BITS  redirect target PC.
- ins_valid_o  output  1  buffer head valid.
- ins_ready_i  input  1  decode accepts head.
- ins_o  output  WORD_WIDTH  head instruction.
- ins_pc_o  output  ADDR_BITS  head PC.
- done_o  output  1  fetch halted (PC past end) and buffer empty.

Behaviour:
- Reset, asynchronous, while arstn=0:
  - pc_q=0, buffer empty (count=0).
  - ins_valid_o=0, ins_o=0, ins_pc_o=0, done_o=0.
  - rom_addr_o=0.
- Reset asserted mid-operation drops all entries immediately. Fetch restarts at PC 0 on the first edge after release.
- PC register:
  - pc_q is ADDR_BITS+1 bits wide; rom_addr_o = pc_q[ADDR_BITS-1:0].
  - halted = (pc_q >= ROM_DEPTH).
- Push (fetch) condition: !halted && !branch_valid_i && (count<2 || pop).
  - On push: enqueue {pc_q[ADDR_BITS-1:0], rom_data_i}; pc_q <= pc_q+1.
- Pop: pop = ins_valid_o && ins_ready_i. The head is dequeued at the edge.
- Simultaneous push and pop:
  - count is unchanged.
  - Allowed at full, giving throughput of 1 instruction/cycle with ready held high.
- Latency: a word fetched in cycle N appears on ins_o with ins_valid_o=1 in cycle N+1. The buffer is registered; there is no combinational ROM-to-decode path.
- ins_valid_o = (count!=0). ins_o and ins_pc_o reflect the head entry. They must stay stable while valid && !ready.
- Redirect (branch_valid_i=1):
  - The buffer is flushed (count<=0) and pc_q <= {1'b0, branch_target_i}.
  - No push occurs that cycle.
  - A pop in the same cycle still counts as accepted by decode; the flush wins over any remaining state.
  - ins_valid_o=0 in the next cycle. The target word is valid one cycle after that (2-cycle redirect bubble).
  - A target >= ROM_DEPTH (only possible when ROM_DEPTH is not a power of two) sets halted immediately; nothing is pushed.
  - A redirect while halted re-arms fetch at the target.
- End of program:
  - After fetching address ROM_DEPTH-1, pc_q = ROM_DEPTH and fetch stops.
  - The buffer drains normally.
  - done_o = halted && count==0, registered-equivalent. It has no glitch on the same edge as the last pop.
- While halted, rom_addr_o is don't-care: it may be pc_q truncation. The bench must not check it.
- ins_ready_i low indefinitely: the buffer fills to 2, push stops, and pc_q holds. No entry is lost or duplicated.

Decomposition:
- fetch_pkg:
  - Existing instruction_t, opcode, reg_t, imm_t.
  - Add fetch_entry_t (struct: pc of ADDR_BITS-sized logic, ins of instruction_t).
  - Add FETCH_BUF_DEPTH=2.
- Sub-module fetch_fifo:
  - Parameterised 2-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - Same clk/arstn.
  - flush has priority over push and pop.
- fetch_stage holds the PC, halt and redirect logic, and instantiates fetch_fifo.
- The bench instantiates the ROM and connects rom_addr_o/rom_data_i.

Test Plan:
- Straight-line run: ROM_DEPTH=16, ins_ready_i=1, no branch -> PCs 0..15 on ins_pc_o in 16 consecutive cycles starting 1 cycle after reset release; done_o=1 the cycle after PC 15 is popped.
- Backpressure: ins_ready_i=0 for cycles 2..7 -> count saturates at 2, ins_o/ins_pc_o hold PC 0, pc_q holds 2; on release, PCs 0,1,2,... delivered with no gap, drop or duplicate.
- Redirect: branch_valid_i=1, target=9, asserted while PC 3 is at the head with 2 entries buffered -> ins_valid_o=0 next cycle, then PC 9 with rom word 9, then 10,...
- Redirect with simultaneous pop at full buffer -> popped entry is counted as accepted, the second entry is discarded, and the next valid PC is the target.
- Halt and re-arm: run to done_o=1, then branch_valid_i=1, target=5 -> done_o drops, PCs 5..15 delivered, done_o reasserts.
- Async reset mid-stream: arstn pulsed low between edges with 2 entries buffered -> ins_valid_o=0 immediately; after release the first delivered PC is 0.
